// File: rtl/div512_seq_if.sv
// Handshake bundle for the sequential divider: operand request channel and
// result channel, each with its own valid/ready pair.
interface div512_seq_if #(
  parameter int N = 256
);
  logic           in_valid;
  logic           in_ready;
  logic [2*N-1:0] dividend;
  logic [N-1:0]   divisor;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] quotient;
  logic [N-1:0]   remainder;
  logic           div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/div512_seq.sv
// Radix-2 restoring divider: 2N-bit dividend by N-bit divisor, one quotient
// bit per clock, valid/ready on both operand and result sides.
module div512_seq #(
  parameter int N     = 256,
  parameter int CNT_W = 9
) (
  input  logic        clk,
  input  logic        reset,
  div512_seq_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_reg;
  state_t state_next;

  // Dividend shifts out at the MSB while quotient bits fill in at the LSB,
  // so after 2N steps this register holds the quotient.
  logic [2*N-1:0]   shift_reg;
  logic [N-1:0]     div_reg;
  logic [N:0]       rem_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             dbz_reg;

  logic [N:0]       trial;
  logic [N:0]       diff;
  logic             fits;
  logic             in_ready_c;
  logic             out_valid_c;
  logic             unused_rem_msb;

  // ---------------- state register ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          state_next = (bus.divisor == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        if (cnt_reg == '0) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------- output logic ----------------
  always_comb begin
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state_reg)
      IDLE:    in_ready_c  = 1'b1;
      DONE:    out_valid_c = 1'b1;
      default: ;
    endcase
  end

  assign bus.in_ready    = in_ready_c;
  assign bus.out_valid   = out_valid_c;
  assign bus.quotient    = shift_reg;
  assign bus.remainder   = rem_reg[N-1:0];
  assign bus.div_by_zero = dbz_reg;

  // R stays below the divisor after every step, so its top bit is always 0
  // and only R[N-1:0] feeds the next trial value.
  assign unused_rem_msb = rem_reg[N];

  // ---------------- datapath ----------------
  assign trial = {rem_reg[N-1:0], shift_reg[2*N-1]};
  assign fits  = (trial >= {1'b0, div_reg});
  assign diff  = trial - {1'b0, div_reg};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_reg <= '0;
      div_reg   <= '0;
      rem_reg   <= '0;
      cnt_reg   <= '0;
      dbz_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            if (bus.divisor != '0) begin
              shift_reg <= bus.dividend;
              div_reg   <= bus.divisor;
              rem_reg   <= '0;
              cnt_reg   <= CNT_W'(2 * N - 1);
              dbz_reg   <= 1'b0;
            end else begin
              shift_reg <= '1;
              rem_reg   <= {1'b0, bus.dividend[N-1:0]};
              dbz_reg   <= 1'b1;
            end
          end
        end
        CALC: begin
          shift_reg <= {shift_reg[2*N-2:0], fits};
          rem_reg   <= fits ? diff : trial;
          if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            dbz_reg <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
